// File: rtl/fft_tx_serializer_pkg.sv
// -----------------------------------------------------------------------------
// fft_tx_serializer_pkg
//
// Shared definitions for the FFT result serializer:
//   state_t        - FSM state encoding (IDLE, HDR, RD, LOAD, SEND, WAIT, DONE)
//   HEADER_DEFAULT - frame-start byte sent ahead of the payload
//   BYTES_PER_BIN  - UART bytes emitted per complex bin (re hi/lo, im hi/lo)
//   BYTE_IDX_W     - width of the per-bin byte index
// -----------------------------------------------------------------------------
package fft_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_RD   = 3'd2,
        ST_LOAD = 3'd3,
        ST_SEND = 3'd4,
        ST_WAIT = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    localparam int BYTES_PER_BIN = 4;
    localparam int BYTE_IDX_W    = $clog2(BYTES_PER_BIN);

endpackage

// File: rtl/fft_tx_serializer.sv
// -----------------------------------------------------------------------------
// fft_tx_serializer
//
// Streams one frame of FFT results to a byte-wide UART transmitter. A frame is
// the HEADER byte followed by every bin in address order, each bin sent as
// re[15:8], re[7:0], im[15:8], im[7:0] (two's complement, unmodified), giving
// 1 + 4*FFT_SIZE bytes per frame.
//
// Ports:
//   i_clk      - single clock
//   i_rst      - asynchronous active-high reset
//   i_start    - one-cycle pulse from the FFT core: results are ready
//   o_rd_addr  - result-memory bin address (synchronous read, 1-cycle latency)
//   i_rd_re    - real part of the addressed bin, valid one cycle after o_rd_addr
//   i_rd_im    - imaginary part, same timing as i_rd_re
//   o_tx_start - one-cycle request to UART_TX for the byte on o_tx_byte
//   o_tx_byte  - byte presented to UART_TX, held until i_tx_done
//   i_tx_done  - one-cycle pulse from UART_TX when the stop bit completes
//   o_busy     - high from i_start acceptance until o_done
//   o_done     - one-cycle pulse after the last byte has been transmitted
//
// The design assumes 2*WORD_SIZE == BYTES_PER_BIN*DATA_LENGTH so that the bin
// shift register empties exactly after BYTES_PER_BIN bytes.
// -----------------------------------------------------------------------------
module fft_tx_serializer
    import fft_tx_serializer_pkg::*;
#(
    parameter int                     FFT_SIZE    = 16,
    parameter int                     WORD_SIZE   = 16,
    parameter int                     DATA_LENGTH = 8,
    parameter logic [DATA_LENGTH-1:0] HEADER      = DATA_LENGTH'(HEADER_DEFAULT)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    output logic [$clog2(FFT_SIZE)-1:0] o_rd_addr,
    input  logic [WORD_SIZE-1:0]        i_rd_re,
    input  logic [WORD_SIZE-1:0]        i_rd_im,
    output logic                        o_tx_start,
    output logic [DATA_LENGTH-1:0]      o_tx_byte,
    input  logic                        i_tx_done,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int ADDR_W  = $clog2(FFT_SIZE);
    localparam int SHREG_W = 2 * WORD_SIZE;

    localparam logic [ADDR_W-1:0]     LAST_BIN  = ADDR_W'(FFT_SIZE - 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_BIN - 1);

    state_t                  state;
    logic [ADDR_W-1:0]       bin_cnt;
    logic [BYTE_IDX_W-1:0]   byte_idx;
    logic [SHREG_W-1:0]      shreg;
    // Set while the header is in flight so WAIT knows to fetch bin 0 next
    // instead of shifting an empty shift register.
    logic                    hdr_pending;

    // The bin counter is the read address: it is stable for the whole bin,
    // so during RD the memory sees the right address and its data lands in
    // time for LOAD.
    assign o_rd_addr = bin_cnt;

    // NOTE: every register in this block is assigned with <= so all of them
    // update together from the same pre-edge values; a blocking assignment
    // here would let later statements see half-updated state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            bin_cnt     <= '0;
            byte_idx    <= '0;
            shreg       <= '0;
            hdr_pending <= 1'b0;
            o_tx_start  <= 1'b0;
            o_tx_byte   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle and are raised only
            // by the state that owns them, which guarantees single-cycle
            // pulses without any extra clear logic.
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        bin_cnt  <= '0;
                        byte_idx <= '0;
                        o_busy   <= 1'b1;
                        state    <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    o_tx_byte   <= HEADER;
                    o_tx_start  <= 1'b1;
                    hdr_pending <= 1'b1;
                    state       <= ST_WAIT;
                end

                // Address is already on o_rd_addr; this cycle is the memory's
                // read latency.
                ST_RD: begin
                    state <= ST_LOAD;
                end

                ST_LOAD: begin
                    shreg <= {i_rd_re, i_rd_im};
                    state <= ST_SEND;
                end

                ST_SEND: begin
                    o_tx_byte  <= shreg[SHREG_W-1 -: DATA_LENGTH];
                    o_tx_start <= 1'b1;
                    state      <= ST_WAIT;
                end

                // o_tx_byte is untouched here, so it stays stable for the
                // whole UART transfer. i_start is ignored in every state but
                // IDLE, including a start that coincides with the last done.
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (hdr_pending) begin
                            hdr_pending <= 1'b0;
                            state       <= ST_RD;
                        end else if (byte_idx != LAST_BYTE) begin
                            shreg    <= shreg << DATA_LENGTH;
                            byte_idx <= byte_idx + BYTE_IDX_W'(1);
                            state    <= ST_SEND;
                        end else if (bin_cnt != LAST_BIN) begin
                            bin_cnt  <= bin_cnt + ADDR_W'(1);
                            byte_idx <= '0;
                            state    <= ST_RD;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_fft_tx_serializer
//
// Bench for fft_tx_serializer. A synchronous result-memory model supplies
// bin k = {re 16'h0100+k, im 16'hFF00-k}; a UART model answers every
// o_tx_start with i_tx_done after a programmable number of cycles. Expected
// frame bytes are pushed to a queue when a frame is started and popped as
// the DUT emits o_tx_start.
// -----------------------------------------------------------------------------
module tb_fft_tx_serializer;

    localparam int FFT_SIZE    = 16;
    localparam int WORD_SIZE   = 16;
    localparam int DATA_LENGTH = 8;
    localparam int BPB         = 4;
    localparam int FRAME_BYTES = 1 + BPB * FFT_SIZE;

    logic                   i_clk = 1'b0;
    logic                   i_rst = 1'b1;
    logic                   i_start = 1'b0;
    logic [3:0]             o_rd_addr;
    logic [WORD_SIZE-1:0]   i_rd_re;
    logic [WORD_SIZE-1:0]   i_rd_im;
    logic                   o_tx_start;
    logic [DATA_LENGTH-1:0] o_tx_byte;
    logic                   i_tx_done = 1'b0;
    logic                   o_busy;
    logic                   o_done;

    always #5 i_clk = ~i_clk;

    fft_tx_serializer #(
        .FFT_SIZE   (FFT_SIZE),
        .WORD_SIZE  (WORD_SIZE),
        .DATA_LENGTH(DATA_LENGTH),
        .HEADER     (8'hA5)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .o_rd_addr (o_rd_addr),
        .i_rd_re   (i_rd_re),
        .i_rd_im   (i_rd_im),
        .o_tx_start(o_tx_start),
        .o_tx_byte (o_tx_byte),
        .i_tx_done (i_tx_done),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    // Synchronous-read result memory, one cycle of latency.
    always @(posedge i_clk) begin
        i_rd_re <= 16'h0100 + 16'(o_rd_addr);
        i_rd_im <= 16'hFF00 - 16'(o_rd_addr);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected byte n of a frame, derived from the memory contents.
    function automatic logic [7:0] frame_byte(input int n);
        logic [15:0] re;
        logic [15:0] im;
        int k;
        int p;
        if (n == 0) return 8'hA5;
        k  = (n - 1) / BPB;
        p  = (n - 1) % BPB;
        re = 16'h0100 + 16'(k);
        im = 16'hFF00 - 16'(k);
        case (p)
            0:       return re[15:8];
            1:       return re[7:0];
            2:       return im[15:8];
            default: return im[7:0];
        endcase
    endfunction

    // Scoreboard and UART-model state.
    logic [7:0] exp_q[$];
    int         tx_lat        = 1;
    int         countdown     = 0;
    int         cyc           = 0;
    int         last_done_cyc = 0;
    int         last_start_cyc = -10;
    int         frame_n       = 0;
    int         tx_total      = 0;
    int         done_cnt      = 0;
    logic [7:0] held_byte     = 8'h00;

    // UART model + output monitor, on the falling edge.
    always @(negedge i_clk) begin
        cyc++;
        i_tx_done = 1'b0;
        if (i_rst) begin
            countdown = 0;
            frame_n   = 0;
        end else begin
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    check("tx_byte_stable", o_tx_byte, held_byte);
                    i_tx_done     = 1'b1;
                    last_done_cyc = cyc;
                end
            end
            if (o_tx_start) begin
                check("tx_start_spacing", (cyc - last_start_cyc) > 1, 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx_start: got byte %0h, required no transfer", o_tx_byte);
                end else begin
                    check("tx_byte", o_tx_byte, exp_q.pop_front());
                end
                if (frame_n > 0) begin
                    // Intervening cycles: SEND within a bin, RD+LOAD+SEND across.
                    check("tx_gap", cyc - last_done_cyc, ((frame_n - 1) % BPB == 0) ? 4 : 2);
                    check("rd_addr", o_rd_addr, (frame_n - 1) / BPB);
                end
                held_byte      = o_tx_byte;
                countdown      = tx_lat;
                last_start_cyc = cyc;
                frame_n++;
                tx_total++;
            end
            if (o_done) begin
                done_cnt++;
                frame_n = 0;
            end
        end
    end

    typedef struct {
        string tag;
        int    lat;         // UART cycles from o_tx_start to i_tx_done
        int    busy_at;     // frame byte at which to pulse i_start again (-1: never)
        bit    start_last;  // pulse i_start together with the final i_tx_done
        int    exp_bytes;
        int    exp_dones;
    } scen_t;

    task automatic pulse_start();
        @(negedge i_clk); #1;
        i_start = 1'b1;
        @(negedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic run_frame(input scen_t s);
        int  guard;
        int  tx0;
        int  d0;
        bit  inject;
        exp_q.delete();
        for (int n = 0; n < FRAME_BYTES; n++) exp_q.push_back(frame_byte(n));
        tx_lat = s.lat;
        tx0    = tx_total;
        d0     = done_cnt;
        inject = (s.busy_at >= 0);
        pulse_start();
        check({s.tag, "_busy_on"}, o_busy, 1);
        guard = 0;
        while (o_done !== 1'b1 && guard < 3000) begin
            @(negedge i_clk); #1;
            guard++;
            if (inject && frame_n >= s.busy_at) begin
                inject = 1'b0;
                check({s.tag, "_busy_at_inject"}, o_busy, 1);
                i_start = 1'b1;
                @(negedge i_clk); #1;
                i_start = 1'b0;
            end
            if (s.start_last && frame_n == FRAME_BYTES && countdown == 1) begin
                @(negedge i_clk); #1;
                check({s.tag, "_coincide_done"}, i_tx_done, 1);
                i_start = 1'b1;
                @(negedge i_clk); #1;
                i_start = 1'b0;
            end
        end
        check({s.tag, "_done_seen"}, o_done, 1);
        check({s.tag, "_busy_off_at_done"}, o_busy, 0);
        repeat (60) @(negedge i_clk);
        #1;
        check({s.tag, "_bytes"}, tx_total - tx0, s.exp_bytes);
        check({s.tag, "_dones"}, done_cnt - d0, s.exp_dones);
        check({s.tag, "_queue_empty"}, exp_q.size(), 0);
        check({s.tag, "_idle_after"}, o_busy, 0);
    endtask

    initial begin
        scen_t tbl[5];
        int    guard;
        int    tx0;
        int    d0;

        tbl[0] = '{"nominal",    1, -1, 1'b0, FRAME_BYTES, 1};
        tbl[1] = '{"start_busy", 1, 10, 1'b0, FRAME_BYTES, 1};
        tbl[2] = '{"slow_uart",  4, -1, 1'b0, FRAME_BYTES, 1};
        tbl[3] = '{"late_start", 2, 40, 1'b0, FRAME_BYTES, 1};
        tbl[4] = '{"coincide",   1, -1, 1'b1, FRAME_BYTES, 1};

        // Reset state.
        repeat (3) @(negedge i_clk);
        #1;
        check("reset_tx_start", o_tx_start, 0);
        check("reset_busy",     o_busy,     0);
        check("reset_done",     o_done,     0);
        check("reset_tx_byte",  o_tx_byte,  0);
        check("reset_rd_addr",  o_rd_addr,  0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // Reset in the middle of a frame.
        exp_q.delete();
        for (int n = 0; n < FRAME_BYTES; n++) exp_q.push_back(frame_byte(n));
        tx_lat = 1;
        d0     = done_cnt;
        pulse_start();
        guard = 0;
        while (frame_n < 20 && guard < 2000) begin
            @(negedge i_clk); #1;
            guard++;
        end
        check("midrst_reached_byte20", frame_n, 20);
        check("midrst_start_before", o_tx_start, 1);
        i_rst = 1'b1;
        #1;
        check("midrst_tx_start", o_tx_start, 0);
        check("midrst_busy",     o_busy,     0);
        check("midrst_tx_byte",  o_tx_byte,  0);
        check("midrst_rd_addr",  o_rd_addr,  0);
        exp_q.delete();
        repeat (3) @(negedge i_clk);
        #1;
        i_rst = 1'b0;
        tx0   = tx_total;
        repeat (50) @(negedge i_clk);
        #1;
        check("midrst_no_done",    done_cnt - d0, 0);
        check("midrst_no_tx",      tx_total - tx0, 0);
        check("midrst_stays_idle", o_busy, 0);
        run_frame('{"after_rst", 1, -1, 1'b0, FRAME_BYTES, 1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule
